// File: rtl/hazard3_ahb_arb_2to1_if.sv
// AHB-Lite link between one master and one slave.
// master modport: the side that issues address phases.
// slave modport : the side that answers them; hready is the bus-level
//                 ready seen by the slave, hreadyout is its own ready.
interface hazard3_ahb_arb_2to1_if #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
);
  logic [W_ADDR-1:0] haddr;
  logic              hwrite;
  logic [1:0]        htrans;
  logic [2:0]        hsize;
  logic [3:0]        hprot;
  logic [2:0]        hburst;
  logic              hmastlock;
  logic [W_DATA-1:0] hwdata;
  logic              hready;
  logic              hreadyout;
  logic              hresp;
  logic [W_DATA-1:0] hrdata;

  modport master (
    output haddr, hwrite, htrans, hsize, hprot, hburst, hmastlock, hwdata,
    input  hready, hresp, hrdata
  );

  modport slave (
    input  haddr, hwrite, htrans, hsize, hprot, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/hazard3_ahb_arb_2to1.sv
// Two-master to one-slave AHB-Lite arbiter (e.g. Hazard3 I and D ports
// merged onto one system bus). A losing address phase is captured in a
// per-port buffer and replayed later; data phases are steered back to the
// port that owns them. Downstream only sees NONSEQ/IDLE, SINGLE bursts.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   s0, s1     : upstream ports (arbiter acts as slave to each master)
//   m          : downstream port (arbiter acts as master)
// Parameters: W_ADDR, W_DATA widths; ROUND_ROBIN 0 = port 0 always wins
// ties, 1 = the most recently granted port loses ties.
module hazard3_ahb_arb_2to1 #(
  parameter int W_ADDR      = 32,
  parameter int W_DATA      = 32,
  parameter int ROUND_ROBIN = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  hazard3_ahb_arb_2to1_if.slave    s0,
  hazard3_ahb_arb_2to1_if.slave    s1,
  hazard3_ahb_arb_2to1_if.master   m
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } own_e;

  own_e              dph_own_r, dph_own_nxt_s;
  logic              buf_vld0_r, buf_vld1_r;
  logic [W_ADDR-1:0] buf_addr0_r, buf_addr1_r;
  logic              buf_write0_r, buf_write1_r;
  logic [2:0]        buf_size0_r, buf_size1_r;
  logic [3:0]        buf_prot0_r, buf_prot1_r;
  logic              hold_r, hold_gnt_r, last_gnt_r;

  logic              live0_s, live1_s, req0_s, req1_s;
  logic              gnt_vld_s, gnt_id_s, issue_s, acc_s, acc0_s, acc1_s;
  logic              use_buf_s;

  // SEQ from a master is re-issued as NONSEQ, so both active types count.
  assign live0_s = ((s0.htrans == HTRANS_NONSEQ) || (s0.htrans == HTRANS_SEQ)) && s0.hready;
  assign live1_s = ((s1.htrans == HTRANS_NONSEQ) || (s1.htrans == HTRANS_SEQ)) && s1.hready;
  assign req0_s  = buf_vld0_r || live0_s;
  assign req1_s  = buf_vld1_r || live1_s;

  // Grant selection; a stalled address phase keeps its previous grant.
  always_comb begin
    gnt_vld_s = 1'b0;
    gnt_id_s  = 1'b0;
    if (hold_r) begin
      gnt_vld_s = 1'b1;
      gnt_id_s  = hold_gnt_r;
    end else if (req0_s && req1_s) begin
      gnt_vld_s = 1'b1;
      if (ROUND_ROBIN != 0) begin
        gnt_id_s = ~last_gnt_r;
      end else begin
        gnt_id_s = 1'b0;
      end
    end else if (req0_s) begin
      gnt_vld_s = 1'b1;
      gnt_id_s  = 1'b0;
    end else if (req1_s) begin
      gnt_vld_s = 1'b1;
      gnt_id_s  = 1'b1;
    end else begin
      gnt_vld_s = 1'b0;
      gnt_id_s  = 1'b0;
    end
  end

  // Gating with rst_n keeps the downstream bus IDLE for the whole reset,
  // even while masters still drive live requests.
  assign issue_s   = gnt_vld_s && rst_n;
  assign acc_s     = issue_s && m.hready;
  assign acc0_s    = acc_s && !gnt_id_s;
  assign acc1_s    = acc_s &&  gnt_id_s;
  assign use_buf_s = gnt_id_s ? buf_vld1_r : buf_vld0_r;

  // Address-phase mux: granted port, buffered copy first. No grant -> port 0.
  always_comb begin
    case ({gnt_id_s, use_buf_s})
      2'b00: begin
        m.haddr = s0.haddr;   m.hwrite = s0.hwrite;
        m.hsize = s0.hsize;   m.hprot  = s0.hprot;
      end
      2'b01: begin
        m.haddr = buf_addr0_r; m.hwrite = buf_write0_r;
        m.hsize = buf_size0_r; m.hprot  = buf_prot0_r;
      end
      2'b10: begin
        m.haddr = s1.haddr;   m.hwrite = s1.hwrite;
        m.hsize = s1.hsize;   m.hprot  = s1.hprot;
      end
      2'b11: begin
        m.haddr = buf_addr1_r; m.hwrite = buf_write1_r;
        m.hsize = buf_size1_r; m.hprot  = buf_prot1_r;
      end
      default: begin
        m.haddr = s0.haddr;   m.hwrite = s0.hwrite;
        m.hsize = s0.hsize;   m.hprot  = s0.hprot;
      end
    endcase
  end

  assign m.htrans    = issue_s ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign m.hburst    = 3'b000;
  assign m.hmastlock = 1'b0;
  assign m.hwdata    = (dph_own_r == OWN_P1) ? s1.hwdata : s0.hwdata;

  // Per-port replay buffers: capture any live request that is not accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_vld0_r   <= 1'b0;            buf_vld1_r   <= 1'b0;
      buf_addr0_r  <= {W_ADDR{1'b0}};  buf_addr1_r  <= {W_ADDR{1'b0}};
      buf_write0_r <= 1'b0;            buf_write1_r <= 1'b0;
      buf_size0_r  <= 3'b000;          buf_size1_r  <= 3'b000;
      buf_prot0_r  <= 4'b0000;         buf_prot1_r  <= 4'b0000;
    end else begin
      if (live0_s && !acc0_s) begin
        buf_vld0_r   <= 1'b1;
        buf_addr0_r  <= s0.haddr;
        buf_write0_r <= s0.hwrite;
        buf_size0_r  <= s0.hsize;
        buf_prot0_r  <= s0.hprot;
      end else if (acc0_s) begin
        buf_vld0_r   <= 1'b0;
      end
      if (live1_s && !acc1_s) begin
        buf_vld1_r   <= 1'b1;
        buf_addr1_r  <= s1.haddr;
        buf_write1_r <= s1.hwrite;
        buf_size1_r  <= s1.hsize;
        buf_prot1_r  <= s1.hprot;
      end else if (acc1_s) begin
        buf_vld1_r   <= 1'b0;
      end
    end
  end

  // Grant hold and round-robin history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_r     <= 1'b0;
      hold_gnt_r <= 1'b0;
      last_gnt_r <= 1'b1;
    end else begin
      hold_r     <= issue_s && !m.hready;
      hold_gnt_r <= gnt_id_s;
      if (acc_s) begin
        last_gnt_r <= gnt_id_s;
      end
    end
  end

  // Data-phase owner: next state.
  always_comb begin
    dph_own_nxt_s = dph_own_r;
    if (m.hready) begin
      if (issue_s) begin
        dph_own_nxt_s = gnt_id_s ? OWN_P1 : OWN_P0;
      end else begin
        dph_own_nxt_s = OWN_NONE;
      end
    end else begin
      dph_own_nxt_s = dph_own_r;
    end
  end

  // Data-phase owner: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dph_own_r <= OWN_NONE;
    end else begin
      dph_own_r <= dph_own_nxt_s;
    end
  end

  // Upstream ready: stall a port while its request waits or is held.
  always_comb begin
    if (buf_vld0_r) begin
      s0.hreadyout = 1'b0;
    end else if (hold_r && !hold_gnt_r) begin
      s0.hreadyout = 1'b0;
    end else if (dph_own_r == OWN_P0) begin
      s0.hreadyout = m.hready;
    end else begin
      s0.hreadyout = 1'b1;
    end
    if (buf_vld1_r) begin
      s1.hreadyout = 1'b0;
    end else if (hold_r && hold_gnt_r) begin
      s1.hreadyout = 1'b0;
    end else if (dph_own_r == OWN_P1) begin
      s1.hreadyout = m.hready;
    end else begin
      s1.hreadyout = 1'b1;
    end
  end

  assign s0.hresp  = (dph_own_r == OWN_P0) && m.hresp;
  assign s1.hresp  = (dph_own_r == OWN_P1) && m.hresp;
  assign s0.hrdata = m.hrdata;
  assign s1.hrdata = m.hrdata;

endmodule

// File: tb/tb_hazard3_ahb_arb_2to1.sv
// Bench for hazard3_ahb_arb_2to1: fixed-priority and round-robin instances
// share the same upstream/downstream stimulus; each port's bus-level hready
// is its own hreadyout, as for a master wired straight to the arbiter.
module tb_hazard3_ahb_arb_2to1;
  localparam logic [1:0] I = 2'b00;
  localparam logic [1:0] N = 2'b10;

  logic        clk = 1'b0;
  logic        d_rst_n, d_w0, d_w1, d_mrdy, d_mresp;
  logic [1:0]  d_t0, d_t1;
  logic [31:0] d_a0, d_a1, d_wd0, d_wd1, d_mrdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    hazard3_ahb_arb_2to1_if #(.W_ADDR(32), .W_DATA(32)) s0_i ();
    hazard3_ahb_arb_2to1_if #(.W_ADDR(32), .W_DATA(32)) s1_i ();
    hazard3_ahb_arb_2to1_if #(.W_ADDR(32), .W_DATA(32)) m_i ();

    assign s0_i.haddr = d_a0;   assign s0_i.hwrite = d_w0;  assign s0_i.htrans = d_t0;
    assign s0_i.hsize = 3'd2;   assign s0_i.hprot  = 4'h3;  assign s0_i.hwdata = d_wd0;
    assign s0_i.hburst = 3'd0;  assign s0_i.hmastlock = 1'b0;
    assign s0_i.hready = s0_i.hreadyout;
    assign s1_i.haddr = d_a1;   assign s1_i.hwrite = d_w1;  assign s1_i.htrans = d_t1;
    assign s1_i.hsize = 3'd1;   assign s1_i.hprot  = 4'hB;  assign s1_i.hwdata = d_wd1;
    assign s1_i.hburst = 3'd0;  assign s1_i.hmastlock = 1'b0;
    assign s1_i.hready = s1_i.hreadyout;
    assign m_i.hready = d_mrdy; assign m_i.hresp = d_mresp; assign m_i.hrdata = d_mrdata;
    assign m_i.hreadyout = d_mrdy;

    hazard3_ahb_arb_2to1 #(.W_ADDR(32), .W_DATA(32), .ROUND_ROBIN(k)) dut (
      .clk   (clk),
      .rst_n (d_rst_n),
      .s0    (s0_i.slave),
      .s1    (s1_i.slave),
      .m     (m_i.master)
    );
  end

  typedef struct {
    logic        rst;
    logic [1:0]  t0;  logic [31:0] a0; logic w0;
    logic [1:0]  t1;  logic [31:0] a1; logic w1;
    logic        mrdy, mresp;
    logic [1:0]  et;  logic ep; logic [31:0] ea; logic ew;
    logic [1:0]  edph;                       // 0 = port 0, 1 = port 1, 2 = none
    logic        er0, er1, es0, es1;         // expected hreadyout / hresp
  } vec_t;

  typedef struct {
    int          idx;
    logic [1:0]  et;  logic [31:0] ea; logic ew; logic [2:0] esz; logic [3:0] epr;
    logic [31:0] ewd, erd;
    logic        er0, er1, es0, es1;
  } exp_t;

  function automatic vec_t mk(logic rst, logic [1:0] t0, logic [31:0] a0, logic w0,
                              logic [1:0] t1, logic [31:0] a1, logic w1,
                              logic mrdy, logic mresp, logic [1:0] et, logic ep,
                              logic [31:0] ea, logic ew, logic [1:0] edph,
                              logic er0, logic er1, logic es0, logic es1);
    vec_t v;
    v.rst = rst;  v.t0 = t0; v.a0 = a0; v.w0 = w0; v.t1 = t1; v.a1 = a1; v.w1 = w1;
    v.mrdy = mrdy; v.mresp = mresp; v.et = et; v.ep = ep; v.ea = ea; v.ew = ew;
    v.edph = edph; v.er0 = er0; v.er1 = er1; v.es0 = es0; v.es1 = es1;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  localparam int NV = 19;
  vec_t vt [NV];
  exp_t sb_q [$];
  int   rr_q [$];
  int   fp_q [$];

  initial begin
    exp_t e;
    //        rst t0 a0        w0 t1 a1        w1 rdy rsp et ep ea        ew dph r0 r1 s0 s1
    vt[0]  = mk(0, I, 32'h0,    0, I, 32'h0,    0, 1, 0, I, 0, 32'h0,    0, 2, 1, 1, 0, 0); // reset
    vt[1]  = mk(1, N, 32'h1000, 0, I, 32'h0,    0, 1, 0, N, 0, 32'h1000, 0, 2, 1, 1, 0, 0); // lone p0
    vt[2]  = mk(1, I, 32'h0,    0, I, 32'h0,    0, 1, 0, I, 0, 32'h0,    0, 0, 1, 1, 0, 0);
    vt[3]  = mk(1, N, 32'h10,   0, N, 32'h20,   1, 1, 0, N, 0, 32'h10,   0, 2, 1, 1, 0, 0); // contention
    vt[4]  = mk(1, I, 32'h0,    0, I, 32'h0,    0, 1, 0, N, 1, 32'h20,   1, 0, 1, 0, 0, 0); // p1 replay
    vt[5]  = mk(1, I, 32'h0,    0, I, 32'h0,    0, 1, 0, I, 0, 32'h0,    0, 1, 1, 1, 0, 0); // p1 wdata
    vt[6]  = mk(1, I, 32'h0,    0, N, 32'h300,  0, 0, 0, N, 1, 32'h300,  0, 2, 1, 1, 0, 0); // stall
    vt[7]  = mk(1, I, 32'h0,    0, I, 32'h0,    0, 0, 0, N, 1, 32'h300,  0, 2, 1, 0, 0, 0);
    vt[8]  = mk(1, N, 32'h400,  1, I, 32'h0,    0, 0, 0, N, 1, 32'h300,  0, 2, 1, 0, 0, 0); // p0 mid-stall
    vt[9]  = mk(1, I, 32'h0,    0, I, 32'h0,    0, 1, 0, N, 1, 32'h300,  0, 2, 0, 0, 0, 0);
    vt[10] = mk(1, I, 32'h0,    0, I, 32'h0,    0, 1, 0, N, 0, 32'h400,  1, 1, 0, 1, 0, 0);
    vt[11] = mk(1, I, 32'h0,    0, I, 32'h0,    0, 1, 0, I, 0, 32'h0,    0, 0, 1, 1, 0, 0);
    vt[12] = mk(1, N, 32'h500,  1, N, 32'h600,  0, 1, 0, N, 0, 32'h500,  1, 2, 1, 1, 0, 0); // error
    vt[13] = mk(1, I, 32'h0,    0, I, 32'h0,    0, 0, 1, N, 1, 32'h600,  0, 0, 0, 0, 1, 0);
    vt[14] = mk(1, I, 32'h0,    0, I, 32'h0,    0, 1, 1, N, 1, 32'h600,  0, 0, 1, 0, 1, 0);
    vt[15] = mk(1, I, 32'h0,    0, I, 32'h0,    0, 1, 0, I, 0, 32'h0,    0, 1, 1, 1, 0, 0);
    vt[16] = mk(1, N, 32'h700,  0, N, 32'h800,  0, 1, 0, N, 0, 32'h700,  0, 2, 1, 1, 0, 0); // reset mid
    vt[17] = mk(0, I, 32'h0,    0, I, 32'h0,    0, 0, 1, I, 0, 32'h0,    0, 2, 1, 1, 0, 0);
    vt[18] = mk(1, I, 32'h0,    0, I, 32'h0,    0, 1, 0, I, 0, 32'h0,    0, 2, 1, 1, 0, 0);

    d_rst_n = 1'b0; d_t0 = I; d_t1 = I; d_a0 = 32'h0; d_a1 = 32'h0; d_w0 = 1'b0; d_w1 = 1'b0;
    d_wd0 = 32'h0; d_wd1 = 32'h0; d_mrdy = 1'b1; d_mresp = 1'b0; d_mrdata = 32'h0;
    repeat (2) @(posedge clk);

    // Table-driven part, checked on the fixed-priority instance.
    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      d_rst_n = vt[i].rst; d_t0 = vt[i].t0; d_a0 = vt[i].a0; d_w0 = vt[i].w0;
      d_t1 = vt[i].t1; d_a1 = vt[i].a1; d_w1 = vt[i].w1;
      d_mrdy = vt[i].mrdy; d_mresp = vt[i].mresp;
      d_wd0 = 32'h0A0A_0000 | 32'(i);
      d_wd1 = 32'h0B0B_0000 | 32'(i);
      d_mrdata = i[0] ? 32'h3501_0FF2 : 32'hCAFE_F00D;
      e.idx = i; e.et = vt[i].et; e.ea = vt[i].ea; e.ew = vt[i].ew;
      e.esz = vt[i].ep ? 3'd1 : 3'd2;
      e.epr = vt[i].ep ? 4'hB : 4'h3;
      e.ewd = (vt[i].edph == 2'd1) ? d_wd1 : d_wd0;
      e.erd = d_mrdata;
      e.er0 = vt[i].er0; e.er1 = vt[i].er1; e.es0 = vt[i].es0; e.es1 = vt[i].es1;
      sb_q.push_back(e);

      @(negedge clk);
      e = sb_q.pop_front();
      chk("m_htrans", e.idx, 32'(g_dut[0].m_i.htrans), 32'(e.et));
      if (e.et == N) begin
        chk("m_haddr",  e.idx, g_dut[0].m_i.haddr,        e.ea);
        chk("m_hwrite", e.idx, 32'(g_dut[0].m_i.hwrite),  32'(e.ew));
        chk("m_hsize",  e.idx, 32'(g_dut[0].m_i.hsize),   32'(e.esz));
        chk("m_hprot",  e.idx, 32'(g_dut[0].m_i.hprot),   32'(e.epr));
      end
      chk("m_hwdata",     e.idx, g_dut[0].m_i.hwdata,          e.ewd);
      chk("m_hburst",     e.idx, 32'(g_dut[0].m_i.hburst),     32'd0);
      chk("m_hmastlock",  e.idx, 32'(g_dut[0].m_i.hmastlock),  32'd0);
      chk("s0_hreadyout", e.idx, 32'(g_dut[0].s0_i.hreadyout), 32'(e.er0));
      chk("s1_hreadyout", e.idx, 32'(g_dut[0].s1_i.hreadyout), 32'(e.er1));
      chk("s0_hresp",     e.idx, 32'(g_dut[0].s0_i.hresp),     32'(e.es0));
      chk("s1_hresp",     e.idx, 32'(g_dut[0].s1_i.hresp),     32'(e.es1));
      chk("s0_hrdata",    e.idx, g_dut[0].s0_i.hrdata,         e.erd);
      chk("s1_hrdata",    e.idx, g_dut[0].s1_i.hrdata,         e.erd);
    end

    // Both masters requesting back to back: round robin alternates from
    // port 0, fixed priority keeps granting port 0.
    @(posedge clk); #1;
    d_rst_n = 1'b0; d_t0 = I; d_t1 = I; d_mrdy = 1'b1; d_mresp = 1'b0;
    @(posedge clk); #1;
    d_rst_n = 1'b1;
    d_t0 = N; d_a0 = 32'h1000_0000; d_w0 = 1'b0;
    d_t1 = N; d_a1 = 32'h2000_0000; d_w1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      rr_q.push_back(k % 2);
      fp_q.push_back(0);
    end
    for (int c = 0; c < 20 && (rr_q.size() > 0 || fp_q.size() > 0); c++) begin
      @(negedge clk);
      if (g_dut[1].m_i.htrans == N && d_mrdy && rr_q.size() > 0) begin
        chk("rr_grant", c, 32'(g_dut[1].m_i.haddr == d_a1), 32'(rr_q.pop_front()));
      end
      if (g_dut[0].m_i.htrans == N && d_mrdy && fp_q.size() > 0) begin
        chk("fp_grant", c, 32'(g_dut[0].m_i.haddr == d_a1), 32'(fp_q.pop_front()));
      end
    end
    chk("rr_grants_left", 0, 32'(rr_q.size()), 32'd0);
    chk("fp_grants_left", 0, 32'(fp_q.size()), 32'd0);

    @(posedge clk); #1;
    d_t0 = I; d_t1 = I;
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
